// File: rtl/nec_ir_encoder_if.sv
// Request/status bundle between a key source and the NEC IR frame encoder.
interface nec_ir_encoder_if;
    logic       send_req;
    logic [7:0] key_code;
    logic       key_hold;
    logic       busy;
    logic       frame_done;
    logic       inf_out;

    modport master (
        output send_req, key_code, key_hold,
        input  busy, frame_done, inf_out
    );

    modport slave (
        input  send_req, key_code, key_hold,
        output busy, frame_done, inf_out
    );
endinterface

// File: rtl/nec_ir_encoder.sv
// NEC IR frame generator: leader, {~key,key,~ADDR,ADDR} LSB first, stop mark, repeat frames while held.
// Build option IR_CARRIER_EN: marks become a 38 kHz carrier (1/3 duty) for direct IR LED drive.
module nec_ir_encoder #(
    parameter int unsigned CLK_FREQ_HZ      = 50_000_000,
    parameter logic [7:0]  ADDR             = 8'h12,
    parameter int unsigned REPEAT_PERIOD_US = 108000,
    parameter int unsigned HOLDOFF_US       = 125000,
    parameter int unsigned LEAD_MARK_US     = 9000,
    parameter int unsigned LEAD_SPACE_US    = 4500,
    parameter int unsigned REP_SPACE_US     = 2250,
    parameter int unsigned MARK_US          = 560,
    parameter int unsigned ZERO_SPACE_US    = 560,
    parameter int unsigned ONE_SPACE_US     = 1690
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    nec_ir_encoder_if.slave ir
);
    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned TICK_DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SEG_MAX  = umax(umax(LEAD_MARK_US, LEAD_SPACE_US),
                                            umax(umax(REP_SPACE_US, MARK_US),
                                                 umax(ZERO_SPACE_US, ONE_SPACE_US)));
    localparam int unsigned SEG_W    = $clog2(SEG_MAX + 1);
    localparam int unsigned FRAME_W  = $clog2(HOLDOFF_US + 1);
    localparam int unsigned BIT_W    = 6;
`ifdef IR_CARRIER_EN
    localparam int unsigned CAR_P    = (CLK_FREQ_HZ + 19_000) / 38_000;
    localparam int unsigned CAR_HI   = (CAR_P + 1) / 3;
    localparam int unsigned CAR_W    = (CAR_P > 1) ? $clog2(CAR_P) : 1;
    localparam logic        INF_RST  = 1'b0;
`else
    localparam logic        INF_RST  = 1'b1;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK,
        S_GAP, S_REP_MARK, S_REP_SPACE, S_REP_STOP, S_HOLDOFF
    } state_e;

    state_e               state_q, state_d;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [SEG_W-1:0]     seg_us_q, seg_us_d;
    logic [FRAME_W-1:0]   frame_us_q, frame_us_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]           key_q, key_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 inf_out_q, inf_out_d;
`ifdef IR_CARRIER_EN
    logic [CAR_W-1:0]     car_cnt_q, car_cnt_d;
`endif

    logic                 tick_c;
    logic                 timed_c;
    logic                 seg_end_c;
    logic                 frame_clr_c;
    logic                 mark_c;
    logic [SEG_W-1:0]     seg_last_c;
    logic [31:0]          word_c;
    logic                 bit_val_c;

    assign tick_c    = (pre_q == PRE_W'(TICK_DIV - 1));
    assign word_c    = {~key_q, key_q, ~ADDR, ADDR};
    assign bit_val_c = word_c[bit_cnt_q[4:0]];

    // Last µs index of the current timed segment; GAP/HOLDOFF/IDLE run off frame_us instead.
    always_comb begin
        seg_last_c = '0;
        timed_c    = 1'b1;
        case (state_q)
            S_LEAD_MARK, S_REP_MARK:             seg_last_c = SEG_W'(LEAD_MARK_US - 1);
            S_LEAD_SPACE:                        seg_last_c = SEG_W'(LEAD_SPACE_US - 1);
            S_BIT_MARK, S_STOP_MARK, S_REP_STOP: seg_last_c = SEG_W'(MARK_US - 1);
            S_BIT_SPACE:                         seg_last_c = bit_val_c ? SEG_W'(ONE_SPACE_US - 1)
                                                                        : SEG_W'(ZERO_SPACE_US - 1);
            S_REP_SPACE:                         seg_last_c = SEG_W'(REP_SPACE_US - 1);
            default:                             timed_c    = 1'b0;
        endcase
    end

    assign seg_end_c = tick_c && timed_c && (seg_us_q == seg_last_c);

    // State register and all datapath registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            pre_q        <= '0;
            seg_us_q     <= '0;
            frame_us_q   <= '0;
            bit_cnt_q    <= '0;
            key_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            inf_out_q    <= INF_RST;
`ifdef IR_CARRIER_EN
            car_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            seg_us_q     <= seg_us_d;
            frame_us_q   <= frame_us_d;
            bit_cnt_q    <= bit_cnt_d;
            key_q        <= key_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            inf_out_q    <= inf_out_d;
`ifdef IR_CARRIER_EN
            car_cnt_q    <= car_cnt_d;
`endif
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        key_d       = key_q;
        frame_clr_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ir.send_req) begin
                    key_d       = ir.key_code;
                    frame_clr_c = 1'b1;
                    state_d     = S_LEAD_MARK;
                end
            end
            S_LEAD_MARK:  if (seg_end_c) state_d = S_LEAD_SPACE;
            S_LEAD_SPACE: begin
                if (seg_end_c) begin
                    bit_cnt_d = '0;
                    state_d   = S_BIT_MARK;
                end
            end
            S_BIT_MARK:   if (seg_end_c) state_d = S_BIT_SPACE;
            S_BIT_SPACE: begin
                if (seg_end_c) begin
                    if (bit_cnt_q == BIT_W'(31)) begin
                        state_d = S_STOP_MARK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        state_d   = S_BIT_MARK;
                    end
                end
            end
            S_STOP_MARK:  if (seg_end_c) state_d = S_GAP;
            S_GAP: begin
                if (tick_c && (frame_us_q == FRAME_W'(REPEAT_PERIOD_US - 1))) begin
                    if (ir.key_hold) begin
                        frame_clr_c = 1'b1;
                        state_d     = S_REP_MARK;
                    end else begin
                        state_d     = S_HOLDOFF;
                    end
                end
            end
            S_REP_MARK:   if (seg_end_c) state_d = S_REP_SPACE;
            S_REP_SPACE:  if (seg_end_c) state_d = S_REP_STOP;
            S_REP_STOP:   if (seg_end_c) state_d = S_GAP;
            S_HOLDOFF: begin
                if (tick_c && (frame_us_q == FRAME_W'(HOLDOFF_US - 1))) state_d = S_IDLE;
            end
            default:      state_d = S_IDLE;
        endcase

        // Prescaler is parked in IDLE so the leader lasts exactly N ticks from acceptance.
        if (state_q == S_IDLE)  pre_d = '0;
        else if (tick_c)        pre_d = '0;
        else                    pre_d = pre_q + PRE_W'(1);

        if (state_d != state_q)      seg_us_d = '0;
        else if (tick_c && timed_c)  seg_us_d = seg_us_q + SEG_W'(1);
        else                         seg_us_d = seg_us_q;

        if (frame_clr_c)                                          frame_us_d = '0;
        else if (tick_c && (frame_us_q != FRAME_W'(HOLDOFF_US)))  frame_us_d = frame_us_q + FRAME_W'(1);
        else                                                      frame_us_d = frame_us_q;
    end

    // Output logic, registered from the next state so the line moves on the entering edge.
    always_comb begin
        busy_d       = (state_d != S_IDLE);
        frame_done_d = ((state_q == S_STOP_MARK) || (state_q == S_REP_STOP)) && (state_d == S_GAP);
        mark_c       = 1'b0;
        case (state_d)
            S_LEAD_MARK, S_BIT_MARK, S_STOP_MARK, S_REP_MARK, S_REP_STOP: mark_c = 1'b1;
            default:                                                      mark_c = 1'b0;
        endcase
`ifdef IR_CARRIER_EN
        if ((state_d != state_q) || (car_cnt_q == CAR_W'(CAR_P - 1))) car_cnt_d = '0;
        else                                                          car_cnt_d = car_cnt_q + CAR_W'(1);
        inf_out_d = mark_c && (car_cnt_d < CAR_W'(CAR_HI));
`else
        inf_out_d = ~mark_c;
`endif
    end

    assign ir.busy       = busy_q;
    assign ir.frame_done = frame_done_q;
    assign ir.inf_out    = inf_out_q;
endmodule
